// File: rtl/nbit_down_timer_if.sv
// Load handshake, run control and status bundle for nbit_down_timer.
// The master drives load and control; the slave (the timer) drives status.
interface nbit_down_timer_if #(
   parameter int CNT_WIDTH = 8,
   parameter int RLD_WIDTH = 4
);
   logic                 load_valid;
   logic [CNT_WIDTH-1:0] load_value;
   logic                 load_ready;
   logic                 start;
   logic                 pause;
   logic                 abort;
   logic                 auto_reload;
   logic [CNT_WIDTH-1:0] counter;
   logic                 busy;
   logic                 done;
   logic [RLD_WIDTH-1:0] reload_cnt;

   modport master (
      output load_valid,
      output load_value,
      output start,
      output pause,
      output abort,
      output auto_reload,
      input  load_ready,
      input  counter,
      input  busy,
      input  done,
      input  reload_cnt
   );

   modport slave (
      input  load_valid,
      input  load_value,
      input  start,
      input  pause,
      input  abort,
      input  auto_reload,
      output load_ready,
      output counter,
      output busy,
      output done,
      output reload_cnt
   );
endinterface

// File: rtl/nbit_down_timer.sv
// Loadable down-counting timer with one-cycle expiry pulse and optional auto-reload.
// Edge priority is abort > load > start > count; all outputs come from registers or state.
module nbit_down_timer #(
   parameter int CNT_WIDTH = 8,
   parameter int RLD_WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   nbit_down_timer_if.slave tmr
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [RLD_WIDTH-1:0] RLD_ZERO = {RLD_WIDTH{1'b0}};
   localparam logic [RLD_WIDTH-1:0] RLD_ONE  = {{(RLD_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [RLD_WIDTH-1:0] RLD_MAX  = {RLD_WIDTH{1'b1}};

   state_t               state_r;
   state_t               state_s;
   logic [CNT_WIDTH-1:0] counter_r;
   logic [CNT_WIDTH-1:0] counter_s;
   logic [CNT_WIDTH-1:0] reload_reg_r;
   logic [CNT_WIDTH-1:0] reload_reg_s;
   logic [RLD_WIDTH-1:0] reload_cnt_r;
   logic [RLD_WIDTH-1:0] reload_cnt_s;
   logic                 done_r;
   logic                 done_s;
   logic                 load_acc_s;

   // Reload-event count sticks at all-ones instead of wrapping.
   function automatic logic [RLD_WIDTH-1:0] sat_inc(input logic [RLD_WIDTH-1:0] value);
      if (value == RLD_MAX) begin
         sat_inc = value;
      end else begin
         sat_inc = value + RLD_ONE;
      end
   endfunction

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         counter_r    <= CNT_ZERO;
         reload_reg_r <= CNT_ZERO;
         reload_cnt_r <= RLD_ZERO;
         done_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         counter_r    <= counter_s;
         reload_reg_r <= reload_reg_s;
         reload_cnt_r <= reload_cnt_s;
         done_r       <= done_s;
      end
   end

   // Next-state and datapath decode.
   always_comb begin
      state_s      = state_r;
      counter_s    = counter_r;
      reload_reg_s = reload_reg_r;
      reload_cnt_s = reload_cnt_r;
      done_s       = 1'b0;
      load_acc_s   = tmr.load_valid & (state_r != ST_RUN);

      if (tmr.abort) begin
         // reload_reg deliberately survives an abort
         state_s      = ST_IDLE;
         counter_s    = CNT_ZERO;
         reload_cnt_s = RLD_ZERO;
      end else if (load_acc_s) begin
         state_s      = ST_ARMED;
         counter_s    = tmr.load_value;
         reload_reg_s = tmr.load_value;
         reload_cnt_s = RLD_ZERO;
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_s = ST_IDLE;
            end
            ST_ARMED: begin
               if (tmr.start) begin
                  state_s = ST_RUN;
               end else begin
                  state_s = ST_ARMED;
               end
            end
            ST_RUN: begin
               if (tmr.pause) begin
                  state_s = ST_RUN;
               end else if (counter_r != CNT_ZERO) begin
                  counter_s = counter_r - CNT_ONE;
               end else begin
                  // zero point: expiry pulse, then reload or stop
                  done_s = 1'b1;
                  if (tmr.auto_reload) begin
                     counter_s    = reload_reg_r;
                     reload_cnt_s = sat_inc(reload_cnt_r);
                     state_s      = ST_RUN;
                  end else begin
                     counter_s = CNT_ZERO;
                     state_s   = ST_IDLE;
                  end
               end
            end
            default: begin
               state_s   = ST_IDLE;
               counter_s = CNT_ZERO;
            end
         endcase
      end
   end

   assign tmr.counter    = counter_r;
   assign tmr.reload_cnt = reload_cnt_r;
   assign tmr.done       = done_r;
   assign tmr.busy       = (state_r == ST_RUN);
   assign tmr.load_ready = (state_r != ST_RUN);

endmodule

// File: tb/tb_nbit_down_timer.sv
// Directed bench for nbit_down_timer: two 3-bit instances, reload counters of 3 and 2 bits.
`timescale 1ns/100ps
module tb_nbit_down_timer;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   nbit_down_timer_if #(.CNT_WIDTH(3), .RLD_WIDTH(3)) ta ();
   nbit_down_timer_if #(.CNT_WIDTH(3), .RLD_WIDTH(2)) tb2 ();

   nbit_down_timer #(.CNT_WIDTH(3), .RLD_WIDTH(3)) dut_a (.clk(clk), .reset(rst), .tmr(ta));
   nbit_down_timer #(.CNT_WIDTH(3), .RLD_WIDTH(2)) dut_b (.clk(clk), .reset(rst), .tmr(tb2));

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      ta.load_valid = 1'b0; ta.load_value = 3'd0; ta.start = 1'b0;
      ta.pause = 1'b0; ta.abort = 1'b0; ta.auto_reload = 1'b0;
      tb2.load_valid = 1'b0; tb2.load_value = 3'd0; tb2.start = 1'b0;
      tb2.pause = 1'b0; tb2.abort = 1'b0; tb2.auto_reload = 1'b0;
      #1.0 rst = 1'b1;
      #0.5;
      checks++; if (ta.counter !== 3'd0) begin errors++; $display("FAIL reset_counter: got %0d expected 0", ta.counter); end
      checks++; if (ta.load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready: got %b expected 1", ta.load_ready); end
      checks++; if (ta.busy !== 1'b0 || ta.done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b expected 00", ta.busy, ta.done); end
      checks++; if (ta.reload_cnt !== 3'd0 || tb2.reload_cnt !== 2'd0) begin errors++; $display("FAIL reset_reload_cnt: got %0d/%0d expected 0/0", ta.reload_cnt, tb2.reload_cnt); end
      #0.7;
      checks++; if (ta.counter !== 3'd0 || ta.busy !== 1'b0 || ta.done !== 1'b0) begin errors++; $display("FAIL reset_hold: got cnt=%0d busy=%b done=%b expected 0/0/0", ta.counter, ta.busy, ta.done); end
      #0.1 rst = 1'b0;
      tick();
      checks++; if (ta.load_ready !== 1'b1 || ta.busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got ready=%b busy=%b expected 1/0", ta.load_ready, ta.busy); end
   endtask

   // load N, start, no reload: counter N..0, done N+1 ticks after start
   task automatic test_countdown(input logic [2:0] n);
      logic [2:0] exp_cnt;
      ta.load_value = n; ta.load_valid = 1'b1; ta.auto_reload = 1'b0;
      tick();
      ta.load_valid = 1'b0;
      checks++; if (ta.counter !== n || ta.busy !== 1'b0 || ta.load_ready !== 1'b1) begin errors++; $display("FAIL armed_%0d: got cnt=%0d busy=%b ready=%b expected %0d/0/1", n, ta.counter, ta.busy, ta.load_ready, n); end
      ta.start = 1'b1;
      tick();
      ta.start = 1'b0;
      checks++; if (ta.counter !== n || ta.busy !== 1'b1 || ta.load_ready !== 1'b0) begin errors++; $display("FAIL run_entry_%0d: got cnt=%0d busy=%b ready=%b expected %0d/1/0", n, ta.counter, ta.busy, ta.load_ready, n); end
      for (int k = 1; k <= int'(n) + 1; k++) begin
         tick();
         exp_cnt = (k <= int'(n)) ? 3'(int'(n) - k) : 3'd0;
         checks++; if (ta.counter !== exp_cnt) begin errors++; $display("FAIL count_%0d_k%0d: got %0d expected %0d", n, k, ta.counter, exp_cnt); end
         checks++; if (ta.done !== (k == int'(n) + 1) || ta.busy !== (k != int'(n) + 1)) begin errors++; $display("FAIL done_busy_%0d_k%0d: got done=%b busy=%b", n, k, ta.done, ta.busy); end
      end
      tick();
      checks++; if (ta.done !== 1'b0 || ta.busy !== 1'b0 || ta.counter !== 3'd0) begin errors++; $display("FAIL after_done_%0d: got done=%b busy=%b cnt=%0d expected 0/0/0", n, ta.done, ta.busy, ta.counter); end
   endtask

   task automatic test_auto_reload;
      ta.load_value = 3'd2; ta.load_valid = 1'b1; ta.auto_reload = 1'b1;
      tick();
      ta.load_valid = 1'b0; ta.start = 1'b1;
      tick();
      ta.start = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         checks++; if (ta.counter !== 3'(2 - (k % 3)) || ta.done !== ((k % 3) == 0)) begin errors++; $display("FAIL reload_k%0d: got cnt=%0d done=%b expected %0d/%b", k, ta.counter, ta.done, 2 - (k % 3), (k % 3) == 0); end
         checks++; if (ta.reload_cnt !== 3'(k / 3)) begin errors++; $display("FAIL reload_cnt_k%0d: got %0d expected %0d", k, ta.reload_cnt, k / 3); end
      end
      // dropping auto_reload takes effect only at the next zero point
      ta.auto_reload = 1'b0;
      tick(); tick();
      checks++; if (ta.counter !== 3'd0 || ta.busy !== 1'b1 || ta.done !== 1'b0) begin errors++; $display("FAIL drop_reload_zero: got cnt=%0d busy=%b done=%b expected 0/1/0", ta.counter, ta.busy, ta.done); end
      tick();
      checks++; if (ta.done !== 1'b1 || ta.busy !== 1'b0 || ta.counter !== 3'd0 || ta.reload_cnt !== 3'd4) begin errors++; $display("FAIL drop_reload_stop: got done=%b busy=%b cnt=%0d rc=%0d expected 1/0/0/4", ta.done, ta.busy, ta.counter, ta.reload_cnt); end
   endtask

   task automatic test_pause;
      logic [2:0] exp_cnt [1:8];
      exp_cnt = '{3'd3, 3'd2, 3'd2, 3'd2, 3'd2, 3'd1, 3'd0, 3'd0};
      ta.load_value = 3'd4; ta.load_valid = 1'b1;
      tick();
      ta.load_valid = 1'b0; ta.start = 1'b1;
      tick();
      ta.start = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         ta.pause = (k >= 3 && k <= 5);
         tick();
         checks++; if (ta.counter !== exp_cnt[k] || ta.done !== (k == 8)) begin errors++; $display("FAIL pause_k%0d: got cnt=%0d done=%b expected %0d/%b", k, ta.counter, ta.done, exp_cnt[k], k == 8); end
      end
      ta.pause = 1'b0;
      checks++; if (ta.busy !== 1'b0 || ta.reload_cnt !== 3'd0) begin errors++; $display("FAIL pause_end: got busy=%b rc=%0d expected 0/0", ta.busy, ta.reload_cnt); end
   endtask

   task automatic test_load_priority_abort;
      ta.load_value = 3'd7; ta.load_valid = 1'b1;
      tick();
      ta.load_value = 3'd3; ta.start = 1'b1;
      tick();
      ta.load_valid = 1'b0;
      checks++; if (ta.counter !== 3'd3 || ta.busy !== 1'b0 || ta.load_ready !== 1'b1) begin errors++; $display("FAIL load_beats_start: got cnt=%0d busy=%b ready=%b expected 3/0/1", ta.counter, ta.busy, ta.load_ready); end
      tick();
      ta.start = 1'b0;
      checks++; if (ta.counter !== 3'd3 || ta.busy !== 1'b1) begin errors++; $display("FAIL start_after_load: got cnt=%0d busy=%b expected 3/1", ta.counter, ta.busy); end
      ta.load_value = 3'd6; ta.load_valid = 1'b1;
      tick();
      ta.load_valid = 1'b0;
      checks++; if (ta.counter !== 3'd2 || ta.busy !== 1'b1) begin errors++; $display("FAIL load_in_run_ignored: got cnt=%0d busy=%b expected 2/1", ta.counter, ta.busy); end
      tick();
      ta.abort = 1'b1;
      tick();
      ta.abort = 1'b0;
      checks++; if (ta.counter !== 3'd0 || ta.busy !== 1'b0 || ta.done !== 1'b0 || ta.load_ready !== 1'b1) begin errors++; $display("FAIL abort: got cnt=%0d busy=%b done=%b ready=%b expected 0/0/0/1", ta.counter, ta.busy, ta.done, ta.load_ready); end
      ta.start = 1'b1;
      tick(); tick();
      ta.start = 1'b0;
      checks++; if (ta.busy !== 1'b0 || ta.done !== 1'b0) begin errors++; $display("FAIL start_in_idle: got busy=%b done=%b expected 0/0", ta.busy, ta.done); end
   endtask

   task automatic test_zero_saturate;
      tb2.load_value = 3'd0; tb2.load_valid = 1'b1; tb2.auto_reload = 1'b1;
      tick();
      tb2.load_valid = 1'b0; tb2.start = 1'b1;
      tick();
      tb2.start = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         checks++; if (tb2.done !== 1'b1 || tb2.counter !== 3'd0 || tb2.busy !== 1'b1) begin errors++; $display("FAIL zero_reload_k%0d: got done=%b cnt=%0d busy=%b expected 1/0/1", k, tb2.done, tb2.counter, tb2.busy); end
         checks++; if (tb2.reload_cnt !== 2'((k > 3) ? 3 : k)) begin errors++; $display("FAIL saturate_k%0d: got %0d expected %0d", k, tb2.reload_cnt, (k > 3) ? 3 : k); end
      end
      tb2.abort = 1'b1;
      tick();
      tb2.abort = 1'b0;
      checks++; if (tb2.reload_cnt !== 2'd0 || tb2.busy !== 1'b0) begin errors++; $display("FAIL abort_clears_rc: got rc=%0d busy=%b expected 0/0", tb2.reload_cnt, tb2.busy); end
      tb2.auto_reload = 1'b0; tb2.load_valid = 1'b1;
      tick();
      tb2.load_valid = 1'b0; tb2.start = 1'b1;
      tick();
      tb2.start = 1'b0;
      checks++; if (tb2.done !== 1'b0 || tb2.busy !== 1'b1) begin errors++; $display("FAIL zero_run_entry: got done=%b busy=%b expected 0/1", tb2.done, tb2.busy); end
      tick();
      checks++; if (tb2.done !== 1'b1 || tb2.busy !== 1'b0) begin errors++; $display("FAIL zero_single_done: got done=%b busy=%b expected 1/0", tb2.done, tb2.busy); end
      tick();
      checks++; if (tb2.done !== 1'b0) begin errors++; $display("FAIL zero_done_once: got %b expected 0", tb2.done); end
   endtask

   task automatic test_reset_midrun;
      ta.load_value = 3'd3; ta.load_valid = 1'b1;
      tick();
      ta.load_valid = 1'b0; ta.start = 1'b1;
      tick();
      ta.start = 1'b0;
      tick();
      #1 rst = 1'b1;
      #1;
      checks++; if (ta.counter !== 3'd0 || ta.busy !== 1'b0 || ta.done !== 1'b0 || ta.load_ready !== 1'b1) begin errors++; $display("FAIL reset_midrun: got cnt=%0d busy=%b done=%b ready=%b expected 0/0/0/1", ta.counter, ta.busy, ta.done, ta.load_ready); end
      #1 rst = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         tick();
         checks++; if (ta.done !== 1'b0 || ta.busy !== 1'b0) begin errors++; $display("FAIL reset_no_done_k%0d: got done=%b busy=%b expected 0/0", k, ta.done, ta.busy); end
      end
   endtask

   initial begin
      test_reset();
      test_countdown(3'd5);
      test_countdown(3'd7);
      test_auto_reload();
      test_pause();
      test_load_priority_abort();
      test_zero_saturate();
      test_reset_midrun();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
